result_matrix_collector: RTL

//  Collects the product matrix streamed out of the multiplier (row-major, one

---
 rtl/result_matrix_collector_pkg.sv | 18 +
 rtl/result_matrix_collector_store.sv | 50 +++++
 rtl/result_matrix_collector.sv | 125 ++++++++++++
 3 files changed

// File: rtl/result_matrix_collector_pkg.sv
// Shared types and helpers for the result matrix collector.
package result_matrix_collector_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_e;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_matrix_collector_store.sv
// n x n element store: one synchronous write port, one combinational read port.
module result_matrix_collector_store
  import result_matrix_collector_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [idx_w(N)-1:0]      wr_row,
  input  logic [idx_w(N)-1:0]      wr_col,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [idx_w(N)-1:0]      rd_row,
  input  logic [idx_w(N)-1:0]      rd_col,
  output logic [DATA_W-1:0]        rd_data_c
);

  localparam int unsigned IDX_W  = idx_w(N);
  localparam int unsigned DEPTH  = N * N;
  localparam int unsigned ADDR_W = idx_w(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] waddr_c;
  logic [ADDR_W-1:0] raddr_c;
  logic              rd_in_range_c;

  assign waddr_c = ADDR_W'(wr_row) * ADDR_W'(N) + ADDR_W'(wr_col);
  assign raddr_c = ADDR_W'(rd_row) * ADDR_W'(N) + ADDR_W'(rd_col);

  // Writer indices wider than the matrix read back as zero.
  assign rd_in_range_c = (32'(rd_row) < N) && (32'(rd_col) < N);

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr_c] <= wr_data;
    end
  end

  always_comb begin
    rd_data_c = '0;
    if (rd_in_range_c) begin
      rd_data_c = mem[raddr_c];
    end
  end

  logic unused_c;
  assign unused_c = &{1'b0, IDX_W[0]};

endmodule

// File: rtl/result_matrix_collector.sv
// Collects a row-major n x n product matrix, then hands it to the file writer.
module result_matrix_collector
  import result_matrix_collector_pkg::*;
#(
  parameter int unsigned n      = 8,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   write_start,
  input  logic                   write_done,
  input  logic [idx_w(n)-1:0]    wr_i,
  input  logic [idx_w(n)-1:0]    wr_j,
  output logic [DATA_W-1:0]      wr_value,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned IDX_W = idx_w(n);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(n - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             write_start_q, write_start_d;
  logic             frame_done_q, frame_done_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             store_we_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= COLLECT;
      row_q         <= '0;
      col_q         <= '0;
      write_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      write_start_q <= write_start_d;
      frame_done_q  <= frame_done_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    write_start_d = write_start_q;
    frame_done_d  = 1'b0;
    store_we_c    = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (in_valid && in_ready_q) begin
          store_we_c = 1'b1;
          if (col_q == LAST_IDX) begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
              row_d   = '0;
              state_d = START;
            end else begin
              row_d = row_q + IDX_W'(1);
            end
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      START: begin
        write_start_d = 1'b1;
        state_d       = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (write_done) begin
          write_start_d = 1'b0;
          frame_done_d  = 1'b1;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        // Hold off new beats until a level-style done has dropped.
        write_start_d = 1'b0;
        if (!write_done) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase

    in_ready_d = (state_d == COLLECT);
    busy_d     = (state_d != COLLECT);
  end

  result_matrix_collector_store #(
    .N      (n),
    .DATA_W (DATA_W)
  ) u_store (
    .clk       (clk),
    .we        (store_we_c),
    .wr_row    (row_q),
    .wr_col    (col_q),
    .wr_data   (in_data),
    .rd_row    (wr_i),
    .rd_col    (wr_j),
    .rd_data_c (wr_value)
  );

  assign in_ready    = in_ready_q;
  assign write_start = write_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule
